// File: rtl/fpu_pkg.sv
// Shared FPU conversion types and constants for the widening converter.
// Holds format codes, FP64 constants, the converter state enum and a leading-zero helper.
package fpu_pkg;

    localparam logic [1:0] FP_TYPE_FP32   = 2'b00;
    localparam logic [1:0] FP_TYPE_FP64   = 2'b01;
    localparam logic [1:0] FP_TYPE_INT32  = 2'b10;
    localparam logic [1:0] FP_TYPE_UINT32 = 2'b11;

    localparam logic [63:0] FP64_CANON_NAN        = 64'h7FF8_0000_0000_0000;
    localparam logic [10:0] FP32_TO_FP64_BIAS_ADJ = 11'd896;
    localparam logic [10:0] INT_EXP_INIT          = 11'd1054;

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        DONE
    } conv_state_t;

    // Leading-zero count of a non-zero 32-bit word.
    function automatic logic [4:0] lzc32(input logic [31:0] v);
        logic [4:0] n;
        logic       found;
        n     = 5'd0;
        found = 1'b0;
        for (int i = 31; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) found = 1'b1;
                else      n = n + 5'd1;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/dp_encoder.sv
// Packs sign, 11-bit biased exponent and 52-bit fraction into an FP64 word.
module dp_encoder (
    input  logic        sign,
    input  logic [10:0] exponent,
    input  logic [51:0] fraction,
    output logic [63:0] fp64
);

    assign fp64 = {sign, exponent, fraction};

endmodule

// File: rtl/sp_to_dp_convert.sv
// FP32/INT32/UINT32 to FP64 widening converter with iterative normalization.
// Define FPU_FAST_NORM_EN to normalize in one step at accept (NORM never entered).
module sp_to_dp_convert
    import fpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] operand_in,
    input  logic [1:0]  input_type,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] result,
    output logic        flag_invalid,
    output logic        flag_overflow,
    output logic        flag_underflow,
    output logic        flag_inexact
);

    conv_state_t state, state_next;

    logic               sign_q;
    logic [10:0]        we_q;
    logic [31:0]        wm_q;
    logic               nv_q;

    logic               accept;
    logic [7:0]         sp_exp;
    logic [22:0]        sp_frac;
    logic               int_sign;
    logic signed [31:0] op_signed;
    logic [31:0]        int_mag;

    logic               init_sign;
    logic [10:0]        init_we;
    logic [31:0]        init_wm;
    logic               init_nv;
    logic               init_norm;

    logic [10:0]        load_we;
    logic [31:0]        load_wm;
    logic               load_norm;

    assign accept    = in_valid && in_ready;
    assign sp_exp    = operand_in[30:23];
    assign sp_frac   = operand_in[22:0];
    assign int_sign  = (input_type == FP_TYPE_INT32) && operand_in[31];
    assign op_signed = signed'(operand_in);
    assign int_mag   = int_sign ? unsigned'(-op_signed) : operand_in;

    // Every class is expressed as sign/exponent/mantissa; mantissa bit 31 is the hidden one.
    always_comb begin
        init_sign = 1'b0;
        init_we   = 11'd0;
        init_wm   = 32'd0;
        init_nv   = 1'b0;
        init_norm = 1'b0;
        case (input_type)
            FP_TYPE_FP32: begin
                if (sp_exp == 8'hFF) begin
                    if (sp_frac != 23'd0) begin
                        init_we = FP64_CANON_NAN[62:52];
                        init_wm = {1'b0, FP64_CANON_NAN[51:21]};
                        init_nv = ~sp_frac[22];
                    end else begin
                        init_sign = operand_in[31];
                        init_we   = 11'h7FF;
                    end
                end else if (sp_exp == 8'h00) begin
                    init_sign = operand_in[31];
                    if (sp_frac != 23'd0) begin
                        init_we   = FP32_TO_FP64_BIAS_ADJ + 11'd1;
                        init_wm   = {1'b0, sp_frac, 8'd0};
                        init_norm = 1'b1;
                    end
                end else begin
                    init_sign = operand_in[31];
                    init_we   = {3'd0, sp_exp} + FP32_TO_FP64_BIAS_ADJ;
                    init_wm   = {1'b1, sp_frac, 8'd0};
                end
            end
            FP_TYPE_FP64: begin
                init_we = FP64_CANON_NAN[62:52];
                init_wm = {1'b0, FP64_CANON_NAN[51:21]};
                init_nv = 1'b1;
            end
            default: begin
                if (int_mag != 32'd0) begin
                    init_sign = int_sign;
                    init_we   = INT_EXP_INIT;
                    init_wm   = int_mag;
                    init_norm = ~int_mag[31];
                end
            end
        endcase
    end

`ifdef FPU_FAST_NORM_EN
    logic [4:0] lz;

    assign lz        = lzc32(init_wm);
    assign load_wm   = init_norm ? (init_wm << lz) : init_wm;
    assign load_we   = init_norm ? (init_we - {6'd0, lz}) : init_we;
    assign load_norm = 1'b0;
`else
    assign load_wm   = init_wm;
    assign load_we   = init_we;
    assign load_norm = init_norm;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NORM exits on the edge where the shifted mantissa gains its top bit.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = load_norm ? NORM : DONE;
            NORM:    if (wm_q[30]) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_q <= 1'b0;
            we_q   <= 11'd0;
            wm_q   <= 32'd0;
            nv_q   <= 1'b0;
        end else if (accept) begin
            sign_q <= init_sign;
            we_q   <= load_we;
            wm_q   <= load_wm;
            nv_q   <= init_nv;
        end else if (state == NORM) begin
            wm_q <= {wm_q[30:0], 1'b0};
            we_q <= we_q - 11'd1;
        end
    end

    dp_encoder u_dp_encoder (
        .sign     (sign_q),
        .exponent (we_q),
        .fraction ({wm_q[30:0], 21'd0}),
        .fp64     (result)
    );

    assign flag_invalid   = nv_q;
    assign flag_overflow  = 1'b0;
    assign flag_underflow = 1'b0;
    assign flag_inexact   = 1'b0;

endmodule

// File: tb/tb_sp_to_dp_convert.sv
// Bench for sp_to_dp_convert: directed table, backpressure and reset sequences, random vs real-arithmetic model.
module tb_sp_to_dp_convert;

`ifdef FPU_FAST_NORM_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] operand_in;
    logic [1:0]  input_type;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result;
    logic        flag_invalid;
    logic        flag_overflow;
    logic        flag_underflow;
    logic        flag_inexact;

    int n_vec = 0;
    int n_bad = 0;

    sp_to_dp_convert dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .operand_in     (operand_in),
        .input_type     (input_type),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .result         (result),
        .flag_invalid   (flag_invalid),
        .flag_overflow  (flag_overflow),
        .flag_underflow (flag_underflow),
        .flag_inexact   (flag_inexact)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [1:0]  t;
        logic [31:0] op;
        logic [63:0] res;
        logic        nv;
        int          lat;
    } vec_t;

    vec_t tbl[16];

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, act, exp_v);
        end
    endtask

    // Reference: value of the source operand computed in real arithmetic, then encoded as FP64.
    function automatic logic [63:0] ref_result(input logic [1:0] t, input logic [31:0] op);
        real    r;
        int     e;
        longint v;
        if (t == 2'b01) return 64'h7FF8_0000_0000_0000;
        if (t == 2'b00) begin
            e = int'(op[30:23]);
            if (e == 255) begin
                if (op[22:0] != 23'd0) return 64'h7FF8_0000_0000_0000;
                return {op[31], 11'h7FF, 52'd0};
            end
            if (e == 0 && op[22:0] == 23'd0) return {op[31], 63'd0};
            r = op[22:0];
            if (e == 0) r = r * (2.0 ** (-149));
            else        r = (1.0 + r / 8388608.0) * (2.0 ** (e - 127));
            if (op[31]) r = -r;
            return $realtobits(r);
        end
        v = (t == 2'b10) ? longint'(signed'(op)) : longint'(op);
        if (v == 0) return 64'd0;
        r = v;
        return $realtobits(r);
    endfunction

    function automatic logic ref_nv(input logic [1:0] t, input logic [31:0] op);
        return (t == 2'b01) || (t == 2'b00 && op[30:23] == 8'hFF && op[22:0] != 23'd0 && !op[22]);
    endfunction

    function automatic int ref_lat(input logic [1:0] t, input logic [31:0] op);
        longint      v;
        logic [31:0] mag;
        int          p;
        if (FAST) return 1;
        if (t == 2'b00 && op[30:23] == 8'h00 && op[22:0] != 23'd0) begin
            p = 22;
            while (p > 0 && !op[p]) p--;
            return 1 + (23 - p);
        end
        if (t[1]) begin
            v = (t == 2'b10) ? longint'(signed'(op)) : longint'(op);
            if (v < 0) v = -v;
            mag = v[31:0];
            if (mag == 32'd0) return 1;
            p = 31;
            while (p > 0 && !mag[p]) p--;
            return 1 + (31 - p);
        end
        return 1;
    endfunction

    task automatic run_op(input logic [1:0] t, input logic [31:0] op, input int hold,
                          output logic [63:0] res, output logic [3:0] flags, output int lat);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            n_vec++;
            n_bad++;
            $display("FAIL in_ready_wait: got 0 required 1");
        end
        input_type = t;
        operand_in = op;
        in_valid   = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) begin
            n_vec++;
            n_bad++;
            $display("FAIL out_valid_wait: got 0 required 1 within 100 cycles");
        end
        repeat (hold) @(negedge clk);
        res   = result;
        flags = {flag_invalid, flag_overflow, flag_underflow, flag_inexact};
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [63:0] res;
        logic [3:0]  flags;
        int          lat;
        logic [1:0]  t;
        logic [31:0] op;

        tbl[0]  = '{2'b00, 32'h3F80_0000, 64'h3FF0_0000_0000_0000, 1'b0, 1};
        tbl[1]  = '{2'b00, 32'h0000_0001, 64'h36A0_0000_0000_0000, 1'b0, 24};
        tbl[2]  = '{2'b10, 32'hFFFF_FFFF, 64'hBFF0_0000_0000_0000, 1'b0, 32};
        tbl[3]  = '{2'b10, 32'h8000_0000, 64'hC1E0_0000_0000_0000, 1'b0, 1};
        tbl[4]  = '{2'b11, 32'hFFFF_FFFF, 64'h41EF_FFFF_FFE0_0000, 1'b0, 1};
        tbl[5]  = '{2'b00, 32'h7F80_0001, 64'h7FF8_0000_0000_0000, 1'b1, 1};
        tbl[6]  = '{2'b00, 32'hFFC0_0000, 64'h7FF8_0000_0000_0000, 1'b0, 1};
        tbl[7]  = '{2'b00, 32'hFF80_0000, 64'hFFF0_0000_0000_0000, 1'b0, 1};
        tbl[8]  = '{2'b00, 32'h8000_0000, 64'h8000_0000_0000_0000, 1'b0, 1};
        tbl[9]  = '{2'b10, 32'h0000_0000, 64'h0000_0000_0000_0000, 1'b0, 1};
        tbl[10] = '{2'b01, 32'h1234_5678, 64'h7FF8_0000_0000_0000, 1'b1, 1};
        tbl[11] = '{2'b00, 32'h0040_0000, 64'h3800_0000_0000_0000, 1'b0, 2};
        tbl[12] = '{2'b10, 32'h0000_0001, 64'h3FF0_0000_0000_0000, 1'b0, 32};
        tbl[13] = '{2'b11, 32'h8000_0000, 64'h41E0_0000_0000_0000, 1'b0, 1};
        tbl[14] = '{2'b10, 32'hFFFF_FFFD, 64'hC008_0000_0000_0000, 1'b0, 31};
        tbl[15] = '{2'b00, 32'h7FC0_0000, 64'h7FF8_0000_0000_0000, 1'b0, 1};

        rst_n      = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        operand_in = 32'd0;
        input_type = 2'b00;
        repeat (3) @(negedge clk);
        check64("reset_in_ready", {63'd0, in_ready}, 64'd1);
        check64("reset_out_valid", {63'd0, out_valid}, 64'd0);
        check64("reset_result", result, 64'd0);
        check64("reset_flags", {60'd0, flag_invalid, flag_overflow, flag_underflow, flag_inexact}, 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            run_op(tbl[i].t, tbl[i].op, i % 3, res, flags, lat);
            check64($sformatf("tbl%0d_result", i), res, tbl[i].res);
            check64($sformatf("tbl%0d_flags", i), {60'd0, flags}, {60'd0, tbl[i].nv, 3'b000});
            check64($sformatf("tbl%0d_latency", i), 64'(lat), 64'(FAST ? 1 : tbl[i].lat));
        end

        // Backpressure: result held while out_ready low, in_valid ignored in DONE.
        run_op(2'b00, 32'h3F80_0000, 0, res, flags, lat);
        @(negedge clk);
        input_type = 2'b00;
        operand_in = 32'h4000_0000;
        in_valid   = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        input_type = 2'b10;
        operand_in = 32'h0000_0007;
        in_valid   = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check64($sformatf("bp%0d_result", k), result, 64'h4000_0000_0000_0000);
            check64($sformatf("bp%0d_in_ready", k), {63'd0, in_ready}, 64'd0);
            check64($sformatf("bp%0d_out_valid", k), {63'd0, out_valid}, 64'd1);
            check64($sformatf("bp%0d_nv", k), {63'd0, flag_invalid}, 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check64("bp_release_in_ready", {63'd0, in_ready}, 64'd1);
        check64("bp_release_out_valid", {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        check64("bp_no_spurious_accept", {63'd0, out_valid}, 64'd0);

        // Reset in the middle of normalizing INT32 1.
        input_type = 2'b10;
        operand_in = 32'h0000_0001;
        in_valid   = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check64("midreset_out_valid", {63'd0, out_valid}, 64'd0);
        check64("midreset_in_ready", {63'd0, in_ready}, 64'd1);
        check64("midreset_result", result, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(2'b10, 32'hFFFF_FFFD, 1, res, flags, lat);
        check64("postreset_result", res, 64'hC008_0000_0000_0000);
        check64("postreset_latency", 64'(lat), 64'(FAST ? 1 : 31));

        for (int i = 0; i < 150; i++) begin
            t  = 2'($urandom_range(0, 3));
            op = $urandom;
            case ($urandom_range(0, 5))
                0: op[30:23] = 8'h00;
                1: op[30:23] = 8'hFF;
                2: op = op >> $urandom_range(0, 31);
                default: ;
            endcase
            run_op(t, op, $urandom_range(0, 3), res, flags, lat);
            check64($sformatf("rnd%0d_t%0d_op%h_result", i, t, op), res, ref_result(t, op));
            check64($sformatf("rnd%0d_flags", i), {60'd0, flags}, {60'd0, ref_nv(t, op), 3'b000});
            check64($sformatf("rnd%0d_latency", i), 64'(lat), 64'(ref_lat(t, op)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
